// File: rtl/trap_monitor.sv
// trap_monitor
//   Commit-stage trap and halt monitor. It watches COMMIT_W retiring lanes
//   per cycle for ebreak. On an ebreak it latches a0 and the trapping PC, then
//   reports a GOOD/BAD trap to the environment through a valid/ack handshake.
//   It also counts cycles and retired instructions. A no-commit watchdog forces
//   a BAD/timeout report when the core stops retiring.
//
// Handshake: trap_valid rises one cycle after the trapping commit. From then on
//   trap_valid and every trap_* output hold steady until trap_ack is sampled
//   high at a clock edge. At that edge the block moves to HALTED and
//   trap_valid drops. trap_ack has no effect while trap_valid is low.
//
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   commit_valid        per-lane retire strobe (lane 0 oldest)
//   commit_inst         lane i instruction at [32i+31:32i]
//   commit_pc           lane i PC at [XLEN*i+XLEN-1:XLEN*i]
//   a0                  x10 as seen by the trapping lane
//   trap_valid/trap_ack report handshake
//   trap_good           latched a0 was zero and no timeout
//   trap_timeout        report was caused by the watchdog
//   trap_code, trap_pc  latched exit code and trapping PC
//   halt                core must stop issuing; sticky until reset
//   cycle_cnt           cycles spent in RUN
//   instret_cnt         retired (effective) instructions
//   dbg_state           current FSM state, for observation only
module trap_monitor #(
  parameter int COMMIT_W = 2,
  parameter int XLEN     = 64,
  parameter int CNT_W    = 64,
  parameter int TIMEOUT  = 1024,
  parameter int TO_W     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COMMIT_W-1:0]      commit_valid,
  input  logic [32*COMMIT_W-1:0]   commit_inst,
  input  logic [XLEN*COMMIT_W-1:0] commit_pc,
  input  logic [XLEN-1:0]          a0,
  output logic                     trap_valid,
  input  logic                     trap_ack,
  output logic                     trap_good,
  output logic                     trap_timeout,
  output logic [XLEN-1:0]          trap_code,
  output logic [XLEN-1:0]          trap_pc,
  output logic                     halt,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         instret_cnt,
  output logic [1:0]               dbg_state
);

  localparam logic [31:0] EBREAK = 32'h00100073;
  // The watchdog fires on the cycle whose increment would reach TIMEOUT.
  // This puts trap_valid exactly TIMEOUT+1 cycles after the last commit.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_REPORT = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [TO_W-1:0] wd_cnt;
  logic [XLEN-1:0] last_pc;

  logic            trap_hit;
  logic [2:0]      eff_cnt;
  logic [XLEN-1:0] eff_pc;
  logic [XLEN-1:0] hit_pc;
  logic            any_commit;
  logic            wd_expire;

  // Lane scan, oldest first. Lanes after the first valid ebreak are squashed.
  // The trap lane itself still counts as retired.
  always_comb begin
    trap_hit = 1'b0;
    eff_cnt  = '0;
    eff_pc   = last_pc;
    hit_pc   = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_valid[i] && !trap_hit) begin
        eff_cnt = eff_cnt + 3'd1;
        eff_pc  = commit_pc[XLEN*i +: XLEN];
        if (commit_inst[32*i +: 32] == EBREAK) begin
          trap_hit = 1'b1;
          hit_pc   = commit_pc[XLEN*i +: XLEN];
        end
      end
    end
  end

  assign any_commit = |commit_valid;
  assign wd_expire  = (TIMEOUT != 0) && !any_commit && (wd_cnt == TO_LAST);
  assign dbg_state  = state;

  always_comb begin
    next_state = state;
    trap_valid = (state == S_REPORT);
    halt       = (state != S_RUN);
    case (state)
      S_RUN:    if (trap_hit || wd_expire) next_state = S_REPORT;
      S_REPORT: if (trap_ack) next_state = S_HALTED;
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_RUN;
      wd_cnt       <= '0;
      last_pc      <= '0;
      cycle_cnt    <= '0;
      instret_cnt  <= '0;
      trap_good    <= 1'b0;
      trap_timeout <= 1'b0;
      trap_code    <= '0;
      trap_pc      <= '0;
    end else begin
      state <= next_state;
      if (state == S_RUN) begin
        cycle_cnt   <= cycle_cnt + 1'b1;
        instret_cnt <= instret_cnt + CNT_W'(eff_cnt);
        last_pc     <= eff_pc;
        if (any_commit || TIMEOUT == 0) wd_cnt <= '0;
        else                            wd_cnt <= wd_cnt + 1'b1;
        // An ebreak takes priority; its commit also clears the watchdog.
        if (trap_hit) begin
          trap_good    <= (a0 == '0);
          trap_timeout <= 1'b0;
          trap_code    <= a0;
          trap_pc      <= hit_pc;
        end else if (wd_expire) begin
          trap_good    <= 1'b0;
          trap_timeout <= 1'b1;
          trap_code    <= '0;
          trap_pc      <= last_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_trap_monitor.sv
// tb_trap_monitor
//   Directed and randomized bench for trap_monitor (COMMIT_W=2, TIMEOUT=8).
//   A transaction-level reference model tracks the run/report/halted phase,
//   the counters, the idle run length and the latched report fields.
module tb_trap_monitor;

  localparam int COMMIT_W = 2;
  localparam int XLEN     = 64;
  localparam int CNT_W    = 64;
  localparam int TIMEOUT  = 8;
  localparam int TO_W     = 16;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] ADDI   = 32'h00500513;

  logic                     clock;
  logic                     reset;
  logic [COMMIT_W-1:0]      commit_valid;
  logic [32*COMMIT_W-1:0]   commit_inst;
  logic [XLEN*COMMIT_W-1:0] commit_pc;
  logic [XLEN-1:0]          a0;
  logic                     trap_valid;
  logic                     trap_ack;
  logic                     trap_good;
  logic                     trap_timeout;
  logic [XLEN-1:0]          trap_code;
  logic [XLEN-1:0]          trap_pc;
  logic                     halt;
  logic [CNT_W-1:0]         cycle_cnt;
  logic [CNT_W-1:0]         instret_cnt;
  logic [1:0]               dbg_state;

  trap_monitor #(
    .COMMIT_W(COMMIT_W), .XLEN(XLEN), .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_inst(commit_inst),
    .commit_pc(commit_pc), .a0(a0),
    .trap_valid(trap_valid), .trap_ack(trap_ack),
    .trap_good(trap_good), .trap_timeout(trap_timeout),
    .trap_code(trap_code), .trap_pc(trap_pc), .halt(halt),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // m_phase: 0 running, 1 reporting, 2 halted
  int               m_phase;
  logic [CNT_W-1:0] m_cycle, m_instret;
  logic [XLEN-1:0]  m_last_pc;
  int               m_idle;
  logic             m_good, m_timeout;
  logic [XLEN-1:0]  m_code, m_pc;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic model_reset();
    m_phase = 0; m_cycle = '0; m_instret = '0; m_last_pc = '0; m_idle = 0;
    m_good = 1'b0; m_timeout = 1'b0; m_code = '0; m_pc = '0;
  endtask

  // Applies one clock edge's worth of behaviour for the given inputs.
  task automatic model_step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                            input logic [63:0] p0, input logic [63:0] p1,
                            input logic [63:0] a0v, input logic ack);
    logic [31:0] ins [2];
    logic [63:0] pcs [2];
    int trap_at;
    int counted;
    ins[0] = i0; ins[1] = i1; pcs[0] = p0; pcs[1] = p1;
    if (m_phase == 0) begin
      m_cycle = m_cycle + 1;
      trap_at = -1;
      counted = 0;
      for (int i = 0; i < 2; i++) begin
        if (v[i] && trap_at < 0) begin
          counted++;
          m_last_pc = pcs[i];
          if (ins[i] == EBREAK) trap_at = i;
        end
      end
      m_instret = m_instret + CNT_W'(counted);
      if (trap_at >= 0) begin
        m_phase = 1; m_good = (a0v == 0); m_timeout = 1'b0;
        m_code = a0v; m_pc = pcs[trap_at]; m_idle = 0;
      end else if (v != 0) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_phase = 1; m_good = 1'b0; m_timeout = 1'b1; m_code = '0; m_pc = m_last_pc;
        end
      end
    end else if (m_phase == 1) begin
      if (ack) m_phase = 2;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("trap_valid",   64'(trap_valid),   64'(m_phase == 1));
    chk("halt",         64'(halt),         64'(m_phase != 0));
    chk("trap_good",    64'(trap_good),    64'(m_good));
    chk("trap_timeout", 64'(trap_timeout), 64'(m_timeout));
    chk("trap_code",    trap_code,         m_code);
    chk("trap_pc",      trap_pc,           m_pc);
    chk("cycle_cnt",    cycle_cnt,         m_cycle);
    chk("instret_cnt",  instret_cnt,       m_instret);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; inputs are sampled at the next rising edge.
  task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [63:0] p0, input logic [63:0] p1,
                      input logic [63:0] a0v, input logic ack);
    commit_valid = v;
    commit_inst  = {i1, i0};
    commit_pc    = {p1, p0};
    a0           = a0v;
    trap_ack     = ack;
    model_step(v, i0, i1, p0, p1, a0v, ack);
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic idle_step();
    step(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b0);
  endtask

  function automatic logic [31:0] rand_inst(input int ebreak_one_in);
    logic [31:0] r;
    r = $urandom;
    if (r == EBREAK) r = r ^ 32'h1;
    if (ebreak_one_in > 0 && $urandom_range(1, ebreak_one_in) == 1) r = EBREAK;
    return r;
  endfunction

  task automatic rand_step(input int ebreak_one_in, input logic ack);
    logic [63:0] a0v;
    a0v = ($urandom_range(0, 1) == 0) ? 64'h0 : {32'h0, $urandom};
    step(2'($urandom_range(0, 3)), rand_inst(ebreak_one_in), rand_inst(ebreak_one_in),
         {32'h8000_0000, $urandom}, {32'h8000_0000, $urandom}, a0v, ack);
  endtask

  // Reset asserted between edges; the outputs must clear immediately.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    commit_valid = '0;
    trap_ack = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int got;
  logic [CNT_W-1:0] ib;

  initial begin
    reset = 1'b1;
    commit_valid = '0; commit_inst = '0; commit_pc = '0; a0 = '0; trap_ack = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset();

    // plain commits, no ebreak
    for (int k = 0; k < 15; k++) rand_step(0, 1'b0);

    // single good ebreak on lane 0
    step(2'b01, EBREAK, 32'h0, 64'h8000_0010, 64'h0, 64'h0, 1'b0);
    chk("single_valid", 64'(trap_valid), 64'd1);
    chk("single_good", 64'(trap_good), 64'd1);
    chk("single_pc", trap_pc, 64'h8000_0010);
    chk("single_halt", 64'(halt), 64'd1);
    step(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1);
    chk("single_acked", 64'(trap_valid), 64'd0);
    for (int k = 0; k < 3; k++) rand_step(3, $urandom_range(0, 1) == 1);

    // bad trap on lane 1 after an addi on lane 0
    do_reset();
    for (int k = 0; k < 4; k++) rand_step(0, 1'b0);
    ib = m_instret;
    step(2'b11, ADDI, EBREAK, 64'h8000_0020, 64'h8000_0024, 64'd5, 1'b0);
    chk("lane1_instret", instret_cnt, ib + 2);
    chk("lane1_good", 64'(trap_good), 64'd0);
    chk("lane1_code", trap_code, 64'd5);
    step(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1);

    // squash of lane 1, then a held report with noisy inputs
    do_reset();
    rand_step(0, 1'b0);
    ib = m_instret;
    step(2'b11, EBREAK, ADDI, 64'h8000_0040, 64'h8000_0044, 64'd0, 1'b0);
    chk("squash_instret", instret_cnt, ib + 1);
    chk("squash_pc", trap_pc, 64'h8000_0040);
    for (int k = 0; k < 5; k++) rand_step(2, 1'b0);
    chk("hold_valid", 64'(trap_valid), 64'd1);
    step(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1);

    // watchdog after a last commit at 0x80000100
    do_reset();
    step(2'b01, ADDI, 32'h0, 64'h8000_0100, 64'h0, 64'h0, 1'b0);
    got = -1;
    for (int k = 1; k <= 14; k++) begin
      idle_step();
      if (trap_valid && got < 0) got = k;
    end
    // 8 idle steps after the commit cycle t lands in cycle t+9
    chk("wd_latency", 64'(got), 64'd8);
    chk("wd_timeout", 64'(trap_timeout), 64'd1);
    chk("wd_pc", trap_pc, 64'h8000_0100);

    // watchdog with no commit ever seen
    do_reset();
    for (int k = 0; k < 10; k++) idle_step();
    chk("wd_nocommit_pc", trap_pc, 64'h0);

    // ebreak on the cycle the watchdog would expire
    do_reset();
    step(2'b01, ADDI, 32'h0, 64'h8000_0200, 64'h0, 64'h0, 1'b0);
    for (int k = 0; k < 7; k++) idle_step();
    step(2'b10, 32'h0, EBREAK, 64'h0, 64'h8000_0300, 64'h0, 1'b0);
    chk("race_timeout", 64'(trap_timeout), 64'd0);
    chk("race_pc", trap_pc, 64'h8000_0300);

    // reset while the report is pending, then normal operation again
    do_reset();
    rand_step(0, 1'b0);
    ib = m_instret;
    for (int k = 0; k < 4; k++) rand_step(0, 1'b0);

    // fully random traffic with sporadic resets
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      else if ($urandom_range(0, 5) == 0) idle_step();
      else rand_step(6, $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trap_monitor.md
# trap_monitor

Parametrised commit-stage trap and halt monitor for the RVNoob core. It watches up to COMMIT_W retiring instructions per cycle and detects `ebreak` (32'h00100073). It latches the exit code in a0 and the trapping PC, then reports GOOD/BAD trap to the simulation environment through a valid/ack handshake. It also keeps cycle and retired-instruction counters and a no-commit watchdog that forces a BAD/timeout halt when the core hangs.

## Interface
- COMMIT_W, 2: number of commit lanes, 1..4; lane 0 is oldest.
- XLEN, 64: data and PC width.
- CNT_W, 64: width of the cycle and instret counters.
- TIMEOUT, 1024: number of consecutive no-commit cycles that trigger the watchdog; 0 disables it.
- TO_W, 16: watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- commit_valid  in  COMMIT_W  per-lane retire strobe.
- commit_inst  in  32*COMMIT_W  lane i uses bits [32i+31:32i].
- commit_pc  in  XLEN*COMMIT_W  lane i PC.
- a0  in  XLEN  architectural x10, already bypassed by upstream to its value as seen by the trapping lane.
- trap_valid  out  1  report pending; held until acknowledged.
- trap_ack  in  1  environment acknowledge.
- trap_good  out  1  1 = latched a0 was 0 and no timeout.
- trap_timeout  out  1  report caused by the watchdog.
- trap_code  out  XLEN  latched a0; 0 on timeout.
- trap_pc  out  XLEN  PC of the ebreak; PC of the last commit on timeout.
- halt  out  1  core must stop issuing; sticky until reset.
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- instret_cnt  out  CNT_W  retired instructions.

## Operation
- FSM has three states: RUN, REPORT, HALTED. Reset enters RUN.
- Lane i is **effective** when commit_valid[i]=1 and every lower lane j<i is not an ebreak with commit_valid[j]=1.
- The **trap lane** is the lowest valid lane whose inst equals 32'h00100073.
- In RUN, each cycle:
  - cycle_cnt increments by 1.
  - instret_cnt increments by the number of effective lanes. The trap lane is counted; lanes above it are squashed and not counted.
  - The last-commit PC register takes the PC of the highest effective lane.
- RUN -> REPORT on a trap lane. That cycle latches trap_code=a0, trap_pc=trap lane PC, trap_good=(a0==0), trap_timeout=0.
- Watchdog:
  - In RUN, the counter clears on any commit_valid bit set, otherwise increments.
  - When it reaches TIMEOUT: RUN -> REPORT with trap_timeout=1, trap_good=0, trap_code=0, trap_pc=last-commit PC.
  - If the last-commit PC register was never written, trap_pc=0.
- REPORT: trap_valid=1 and all trap_* outputs are held stable. On trap_ack=1 sampled at an edge -> HALTED.
- HALTED: trap_valid=0 and trap_* keep their latched values. The block stays in HALTED until reset.
- Outside RUN: commit inputs are ignored and counters and watchdog are frozen.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset values: trap_valid=0, trap_good=0, trap_timeout=0, trap_code=0, trap_pc=0, halt=0, cycle_cnt=0, instret_cnt=0, watchdog=0, state RUN.
- Reset is asynchronous and overrides everything, including a pending REPORT; the trap is lost.
- Detection latency is 1 cycle. An ebreak on the commit port in cycle t gives trap_valid=1 and halt=1 from cycle t+1.
- The counters' final value includes cycle t and the lanes committed in cycle t.
- trap_ack is only honoured while trap_valid=1. If ack is high at the first REPORT edge, trap_valid drops after exactly one cycle.
- Simultaneous ebreak and watchdog expiry in the same cycle: ebreak wins, since the commit also clears the watchdog.
- With TIMEOUT=N, after the last commit in cycle t with no further commits, trap_valid rises at cycle t+N+1.

## Test plan
- Single ebreak, COMMIT_W=2:
  - Stimulus: lane0 ebreak with a0=0, pc=0x80000010.
  - Response: next cycle trap_valid=1, trap_good=1, trap_code=0, trap_pc=0x80000010, halt=1.
  - Then ack -> HALTED with trap_valid=0.
- Bad trap on lane 1:
  - Stimulus: lane0 addi and lane1 ebreak in the same cycle, a0=5.
  - Response: trap_good=0, trap_code=5, instret_cnt increased by 2.
- Squash:
  - Stimulus: lane0 ebreak, lane1 valid.
  - Response: instret_cnt +1 only; trap_pc=lane0 PC.
- Watchdog:
  - Stimulus: TIMEOUT=8, last commit at pc=0x80000100, then no commits.
  - Response: trap_valid 9 cycles after that commit, with trap_timeout=1, trap_good=0, trap_pc=0x80000100.
- Handshake hold:
  - Stimulus: delay ack by 5 cycles while driving commits with random trap_* inputs.
  - Response: outputs stay stable, counters frozen, commits ignored.
- Reset mid-REPORT:
  - Stimulus: assert reset asynchronously while trap_valid=1.
  - Response: all outputs are 0 immediately; the block is back in RUN after reset deasserts.
